ifu_icache_tag_ways: RTL and testbench
======================================

# ifu_icache_tag_ways

Set-associative tag store for the IFU instruction cache. It holds NUM_WAYS ways of tag+valid in per-way SRAMs and answers lookups with hit, hit-way and victim-way one cycle later. It invalidates itself by walking every set after reset or on a flush request. It sits between the IFU fetch stage, which drives lookups, and the icache refill logic, which drives fills.

## Interface

Parameters:
- INDEX_WIDTH, 6, set index width; NUM_SETS = 2^INDEX_WIDTH
- TAG_WIDTH, 52, tag width
- NUM_WAYS, 4, associativity; power of two, at least 2; WAY_WIDTH = log2(NUM_WAYS)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- lookup_valid_i  in  1  lookup request
- lookup_ready_o  out  1  lookup can be accepted this cycle
- lookup_index_i  in  INDEX_WIDTH  lookup set
- lookup_tag_i  in  TAG_WIDTH  lookup tag
- resp_valid_o  out  1  response valid (single-cycle pulse, no backpressure)
- resp_hit_o  out  1  some valid way's tag matched
- resp_way_o  out  WAY_WIDTH  lowest matching way; 0 on miss
- resp_victim_o  out  WAY_WIDTH  way to refill on miss
- fill_valid_i  in  1  write a tag
- fill_index_i  in  INDEX_WIDTH  fill set
- fill_way_i  in  WAY_WIDTH  fill way
- fill_tag_i  in  TAG_WIDTH  fill tag; stored with valid=1
- flush_i  in  1  invalidate all sets (pulse)
- busy_o  out  1  flush walk in progress

## Operation

- Storage: one SRAM per way, word = {valid, tag}, depth NUM_SETS, single port.
- Per-set round-robin pointers (NUM_SETS x WAY_WIDTH) are held in flops.
- FSM states:
  - FLUSH: counter walks sets 0..NUM_SETS-1, one per cycle, writing {0, 0} to all ways; busy_o=1; lookup_ready_o=0; fill_valid_i must be low (bench asserts this).
  - IDLE: normal operation.
- Transitions:
  - Reset (rst_i low) forces FLUSH with counter 0.
  - FLUSH -> IDLE after set NUM_SETS-1 is written.
  - IDLE -> FLUSH when flush_i=1.
  - flush_i during FLUSH is ignored; the walk continues unchanged.
- Round-robin pointers reset to 0 on rst_i and are cleared to 0 on every entry to FLUSH.
- Lookup accept: lookup_valid_i & lookup_ready_o. lookup_ready_o = IDLE & !fill_valid_i, so a fill has priority and stalls the lookup.
- Response, cycle after accept:
  - hit = OR over ways of (valid & tag == lookup_tag).
  - resp_way_o = lowest matching way.
  - resp_victim_o = lowest invalid way if any exists, else the set's round-robin pointer.
- Fill: writes {1, fill_tag_i} to fill_way_i at fill_index_i. The set's pointer becomes fill_way_i+1, mod NUM_WAYS with natural wrap.
- Duplicate tags in a set are a caller error; the block still reports the lowest way.

## Timing

- Reset values: resp_valid_o=0, resp_hit_o=0, resp_way_o=0, resp_victim_o=0, busy_o=1, lookup_ready_o=0.
- Lookup latency is exactly 1 cycle. Response fields are valid only while resp_valid_o=1.
- A fill in cycle N is visible to a lookup accepted in cycle N+1.
- Full flush takes NUM_SETS cycles; busy_o falls the cycle after the last set is written. With defaults, flush_i seen at edge E gives busy_o high for 64 cycles starting E+1.
- An accepted lookup whose response cycle coincides with FLUSH entry still produces resp_valid_o with pre-flush data. No new lookups are accepted during FLUSH.
- rst_i asserted mid-walk restarts the walk from set 0.
- A fill and flush_i in the same cycle: the fill is written, then the flush starts and invalidates it.

## Structure

- Package ifu_icache_pkg holds:
  - the FSM state enum (IDLE, FLUSH)
  - the default parameter constants
  - the {valid, tag} entry typedef width helper
- Sub-module ifu_icache_tag_way: one way, wrapping fake_sram (width TAG_WIDTH+1) plus its compare logic. The top instantiates NUM_WAYS of these in a generate loop.
- FSM, flush counter, round-robin pointers and victim/hit-priority encoders live in the top.

## Test plan

- Release reset -> busy_o=1 for 64 cycles, lookup_ready_o=0 throughout; then a lookup of set 5, tag 0x123 -> resp_hit_o=0, resp_victim_o=0.
- Fill set 5 ways 0..3 with tags 0xA..0xD. Lookup tag 0xC -> hit=1, way=2. Lookup tag 0xE -> hit=0, victim=0, because the pointer wrapped to 0 after the fill of way 3.
- Fill set 9 way 1 only, then look up set 9 with a missing tag -> victim=0 (lowest invalid way). Fill way 0, then miss again -> victim=2.
- Fill and lookup_valid_i asserted together -> lookup_ready_o=0 in that cycle. The lookup is accepted next cycle and hits the just-filled tag.
- Populate sets, pulse flush_i, and pulse flush_i again mid-walk -> walk length still 64 cycles. Every later lookup misses and every victim is 0.
- Assert rst_i at flush cycle 30 -> outputs return to reset values and the walk restarts at set 0, taking a full 64 cycles.

Source files
------------

// File: rtl/ifu_icache_tag_ways_pkg.sv
// Shared definitions for the IFU instruction-cache tag store.
//
// Contents:
//   DEFAULT_*    default geometry used by the tag store and its interface
//   tag_state_e  controller state (normal operation or invalidation walk)
//   entry_width  width of one stored {valid, tag} word for a given tag width
package ifu_icache_pkg;

    localparam int DEFAULT_INDEX_WIDTH = 6;
    localparam int DEFAULT_TAG_WIDTH   = 52;
    localparam int DEFAULT_NUM_WAYS    = 4;

    // IDLE serves lookups and fills; FLUSH walks every set writing invalid entries.
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } tag_state_e;

    // A stored entry is the tag with a valid bit on top.
    function automatic int entry_width(input int tag_width);
        return tag_width + 1;
    endfunction

endpackage

// File: rtl/ifu_icache_tag_ways_if.sv
// Bus between the tag store, the IFU fetch stage (lookups) and the refill
// logic (fills, flush).
//
// Signals:
//   lookup_*_i / lookup_ready_o  lookup request and its acceptance
//   resp_*_o                     one-cycle response pulse: hit, hit way, victim way
//   fill_*_i                     tag write into one way of one set
//   flush_i / busy_o             invalidate-all request and walk-in-progress flag
// Modports:
//   master  requester side (fetch stage, refill logic, bench)
//   slave   the tag store
interface ifu_icache_tag_ways_if #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 52,
    parameter int WAY_WIDTH   = 2
);
    logic                   lookup_valid_i;
    logic                   lookup_ready_o;
    logic [INDEX_WIDTH-1:0] lookup_index_i;
    logic [TAG_WIDTH-1:0]   lookup_tag_i;
    logic                   resp_valid_o;
    logic                   resp_hit_o;
    logic [WAY_WIDTH-1:0]   resp_way_o;
    logic [WAY_WIDTH-1:0]   resp_victim_o;
    logic                   fill_valid_i;
    logic [INDEX_WIDTH-1:0] fill_index_i;
    logic [WAY_WIDTH-1:0]   fill_way_i;
    logic [TAG_WIDTH-1:0]   fill_tag_i;
    logic                   flush_i;
    logic                   busy_o;

    modport master (
        output lookup_valid_i, lookup_index_i, lookup_tag_i,
        output fill_valid_i, fill_index_i, fill_way_i, fill_tag_i, flush_i,
        input  lookup_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_victim_o, busy_o
    );

    modport slave (
        input  lookup_valid_i, lookup_index_i, lookup_tag_i,
        input  fill_valid_i, fill_index_i, fill_way_i, fill_tag_i, flush_i,
        output lookup_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_victim_o, busy_o
    );

endinterface

// File: rtl/fake_sram.sv
// Behavioural single-port SRAM: synchronous write, registered read-first data.
//
// Ports:
//   clk_i    clock
//   we_i     write enable for addr_i this cycle
//   addr_i   read/write address
//   wdata_i  write data
//   rdata_o  data at addr_i as it was before this edge's write, one cycle later
module fake_sram #(
    parameter int WIDTH      = 53,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Read data is sampled from the array before the write lands.
    always_comb begin
        rdata_d = mem_q[addr_i];
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ifu_icache_tag_way.sv
// One way of the tag store: its {valid, tag} SRAM plus the tag comparator.
//
// Ports:
//   clk_i      clock
//   we_i       write wdata_i at addr_i
//   addr_i     set index to read or write
//   wdata_i    {valid, tag} word to store
//   cmp_tag_i  tag to compare against the word read out last cycle
//   match_o    stored entry is valid and its tag equals cmp_tag_i
//   valid_o    stored entry is valid
module ifu_icache_tag_way #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 52
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [INDEX_WIDTH-1:0] addr_i,
    input  logic [TAG_WIDTH:0]     wdata_i,
    input  logic [TAG_WIDTH-1:0]   cmp_tag_i,
    output logic                   match_o,
    output logic                   valid_o
);

    logic [TAG_WIDTH:0] rdata;

    fake_sram #(
        .WIDTH      (TAG_WIDTH + 1),
        .DEPTH      (1 << INDEX_WIDTH),
        .ADDR_WIDTH (INDEX_WIDTH)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata)
    );

    assign valid_o = rdata[TAG_WIDTH];
    assign match_o = valid_o && (rdata[TAG_WIDTH-1:0] == cmp_tag_i);

endmodule

// File: rtl/ifu_icache_tag_ways.sv
// Set-associative tag store for the IFU instruction cache. Answers a lookup
// one cycle after acceptance with hit, lowest hit way and a victim way, takes
// tag fills from the refill logic, and invalidates every set by walking them
// after reset or on a flush request.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset; restarts the invalidation walk
//   bus    lookup / response / fill / flush bus (slave side)
module ifu_icache_tag_ways
    import ifu_icache_pkg::*;
#(
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int TAG_WIDTH   = DEFAULT_TAG_WIDTH,
    parameter int NUM_WAYS    = DEFAULT_NUM_WAYS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ifu_icache_tag_ways_if.slave bus
);

    localparam int NUM_SETS    = 1 << INDEX_WIDTH;
    localparam int WAY_WIDTH   = $clog2(NUM_WAYS);
    localparam int ENTRY_WIDTH = entry_width(TAG_WIDTH);
    localparam logic [INDEX_WIDTH-1:0] LAST_SET = INDEX_WIDTH'(NUM_SETS - 1);

    tag_state_e             state_q, state_d;
    logic [INDEX_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [WAY_WIDTH-1:0]   rr_q [NUM_SETS];
    logic [WAY_WIDTH-1:0]   rr_d [NUM_SETS];
    logic                   resp_valid_q, resp_valid_d;
    logic [TAG_WIDTH-1:0]   lookup_tag_q, lookup_tag_d;
    logic [WAY_WIDTH-1:0]   victim_ptr_q, victim_ptr_d;

    logic                   flushing;
    logic                   lookup_ready;
    logic                   lookup_accept;
    logic [NUM_WAYS-1:0]    way_we;
    logic [NUM_WAYS-1:0]    way_match;
    logic [NUM_WAYS-1:0]    way_valid;
    logic [INDEX_WIDTH-1:0] sram_addr;
    logic [ENTRY_WIDTH-1:0] sram_wdata;
    logic                   any_invalid;
    logic [WAY_WIDTH-1:0]   hit_way;
    logic [WAY_WIDTH-1:0]   invalid_way;

    assign flushing      = (state_q == FLUSH);
    assign lookup_ready  = (state_q == IDLE) && !bus.fill_valid_i;
    assign lookup_accept = bus.lookup_valid_i && lookup_ready;

    // The SRAMs are single ported, so one address feeds all ways: the walk
    // counter while flushing, the fill set when a fill is present (lookups are
    // stalled then), otherwise the lookup set.
    always_comb begin
        sram_addr  = bus.lookup_index_i;
        sram_wdata = {1'b1, bus.fill_tag_i};
        way_we     = '0;
        if (flushing) begin
            sram_addr  = flush_cnt_q;
            sram_wdata = '0;
            way_we     = '1;
        end else if (bus.fill_valid_i) begin
            sram_addr = bus.fill_index_i;
            for (int w = 0; w < NUM_WAYS; w++) begin
                way_we[w] = (bus.fill_way_i == WAY_WIDTH'(w));
            end
        end
    end

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        ifu_icache_tag_way #(
            .INDEX_WIDTH (INDEX_WIDTH),
            .TAG_WIDTH   (TAG_WIDTH)
        ) u_way (
            .clk_i     (clk_i),
            .we_i      (way_we[g]),
            .addr_i    (sram_addr),
            .wdata_i   (sram_wdata),
            .cmp_tag_i (lookup_tag_q),
            .match_o   (way_match[g]),
            .valid_o   (way_valid[g])
        );
    end

    // Priority encoders: scanning from the top way down lets the lowest
    // matching / lowest invalid way win.
    always_comb begin
        hit_way     = '0;
        invalid_way = '0;
        any_invalid = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                hit_way = WAY_WIDTH'(w);
            end
            if (!way_valid[w]) begin
                invalid_way = WAY_WIDTH'(w);
                any_invalid = 1'b1;
            end
        end
    end

    // Next-state logic. The round-robin pointer of the looked-up set is
    // captured at accept so a response overlapping flush entry still reports
    // pre-flush state. A fill moves its set's pointer past the filled way; a
    // flush request in the same cycle then clears every pointer.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        rr_d         = rr_q;
        resp_valid_d = lookup_accept;
        lookup_tag_d = lookup_tag_q;
        victim_ptr_d = victim_ptr_q;
        if (lookup_accept) begin
            lookup_tag_d = bus.lookup_tag_i;
            victim_ptr_d = rr_q[bus.lookup_index_i];
        end
        case (state_q)
            IDLE: begin
                if (bus.fill_valid_i) begin
                    rr_d[bus.fill_index_i] = bus.fill_way_i + 1'b1;
                end
                if (bus.flush_i) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                    for (int s = 0; s < NUM_SETS; s++) begin
                        rr_d[s] = '0;
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == LAST_SET) begin
                    state_d = IDLE;
                end
            end
            default: state_d = FLUSH;
        endcase
    end

    // Reset lands in FLUSH at set 0 so the SRAM contents are invalidated
    // before any lookup is accepted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= FLUSH;
            flush_cnt_q  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_q[s] <= '0;
            end
            resp_valid_q <= 1'b0;
            lookup_tag_q <= '0;
            victim_ptr_q <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            rr_q         <= rr_d;
            resp_valid_q <= resp_valid_d;
            lookup_tag_q <= lookup_tag_d;
            victim_ptr_q <= victim_ptr_d;
        end
    end

    // Response fields are forced to zero outside the response pulse.
    assign bus.lookup_ready_o = lookup_ready;
    assign bus.busy_o         = flushing;
    assign bus.resp_valid_o   = resp_valid_q;
    assign bus.resp_hit_o     = resp_valid_q && (|way_match);
    assign bus.resp_way_o     = resp_valid_q ? hit_way : '0;
    assign bus.resp_victim_o  = !resp_valid_q ? '0 : (any_invalid ? invalid_way : victim_ptr_q);

endmodule

// File: tb/tb_ifu_icache_tag_ways.sv
// Self-checking bench for ifu_icache_tag_ways: directed stimulus with literal
// expectations, plus a per-cycle comparison against a set/way array model.
module tb_ifu_icache_tag_ways;

    localparam int IW       = 6;
    localparam int TW       = 52;
    localparam int WW       = 2;
    localparam int NSETS    = 64;
    localparam int NWAYS    = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    int checks   = 0;
    int failures = 0;
    logic last_ready;

    ifu_icache_tag_ways_if #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW), .WAY_WIDTH(WW)) bus ();

    ifu_icache_tag_ways #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW), .NUM_WAYS(NWAYS)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: contents of every set/way, per-set round-robin pointer, and the
    // number of cycles the invalidation walk still has to run.
    logic [TW-1:0] m_tag   [NSETS][NWAYS];
    bit            m_valid [NSETS][NWAYS];
    int            m_ptr   [NSETS];
    int            busy_rem;
    bit            exp_valid;
    int            exp_hit, exp_way, exp_victim;

    always @(posedge clk_i) begin
        bit idle, acc, found;
        int idx;
        if (!rst_i) begin
            for (int s = 0; s < NSETS; s++) begin
                m_ptr[s] = 0;
                for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 0;
            end
            busy_rem  = NSETS;
            exp_valid = 0;
        end else begin
            idle = (busy_rem == 0);
            acc  = bus.lookup_valid_i && idle && !bus.fill_valid_i;
            exp_valid = acc;
            if (acc) begin
                idx = int'(bus.lookup_index_i);
                found = 0; exp_hit = 0; exp_way = 0;
                for (int w = 0; w < NWAYS; w++) begin
                    if (!found && m_valid[idx][w] && m_tag[idx][w] == bus.lookup_tag_i) begin
                        found = 1; exp_hit = 1; exp_way = w;
                    end
                end
                found = 0; exp_victim = m_ptr[idx];
                for (int w = 0; w < NWAYS; w++) begin
                    if (!found && !m_valid[idx][w]) begin
                        found = 1; exp_victim = w;
                    end
                end
            end
            if (bus.fill_valid_i && !idle) begin
                failures++;
                $display("[TB] FAIL fill_during_flush: fill_valid_i=1 while busy");
            end
            if (bus.fill_valid_i && idle) begin
                idx = int'(bus.fill_index_i);
                m_tag[idx][bus.fill_way_i]   = bus.fill_tag_i;
                m_valid[idx][bus.fill_way_i] = 1;
                m_ptr[idx] = (int'(bus.fill_way_i) + 1) % NWAYS;
            end
            if (!idle) begin
                busy_rem--;
            end else if (bus.flush_i) begin
                busy_rem = NSETS;
                for (int s = 0; s < NSETS; s++) begin
                    m_ptr[s] = 0;
                    for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 0;
                end
            end
        end
        #1;
        checkOutput("model_resp_valid", 64'(bus.resp_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            checkOutput("model_resp_hit", 64'(bus.resp_hit_o), 64'(exp_hit));
            if (exp_hit != 0) checkOutput("model_resp_way", 64'(bus.resp_way_o), 64'(exp_way));
            checkOutput("model_resp_victim", 64'(bus.resp_victim_o), 64'(exp_victim));
        end
        checkOutput("model_busy", 64'(bus.busy_o), 64'((!rst_i || busy_rem > 0) ? 1 : 0));
        checkOutput("model_ready", 64'(bus.lookup_ready_o),
                    64'((rst_i && busy_rem == 0 && !bus.fill_valid_i) ? 1 : 0));
    end

    // Drive one cycle of inputs at a falling edge, note lookup_ready_o while
    // they are applied, then return at the next falling edge with inputs idle.
    task automatic applyStimulus(input bit lv, input int li, input logic [TW-1:0] lt,
                                 input bit fv, input int fi, input int fw,
                                 input logic [TW-1:0] ft, input bit fl);
        bus.lookup_valid_i = lv;
        bus.lookup_index_i = IW'(li);
        bus.lookup_tag_i   = lt;
        bus.fill_valid_i   = fv;
        bus.fill_index_i   = IW'(fi);
        bus.fill_way_i     = WW'(fw);
        bus.fill_tag_i     = ft;
        bus.flush_i        = fl;
        #1 last_ready = bus.lookup_ready_o;
        @(negedge clk_i);
        bus.lookup_valid_i = 1'b0;
        bus.fill_valid_i   = 1'b0;
        bus.flush_i        = 1'b0;
    endtask

    task automatic doLookup(input int idx, input logic [TW-1:0] tag, input bit fl);
        applyStimulus(1'b1, idx, tag, 1'b0, 0, 0, '0, fl);
    endtask

    task automatic doFill(input int idx, input int way, input logic [TW-1:0] tag, input bit fl);
        applyStimulus(1'b0, 0, '0, 1'b1, idx, way, tag, fl);
    endtask

    // Count falling edges with busy_o high, optionally pulsing flush_i mid-walk.
    task automatic countBusy(input int pulse_at, output int n, output bit saw_ready);
        n = 0;
        saw_ready = 0;
        while (bus.busy_o && n < 200) begin
            if (bus.lookup_ready_o) saw_ready = 1;
            bus.flush_i = (n == pulse_at);
            n++;
            @(negedge clk_i);
        end
        bus.flush_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit saw_ready;
        bus.lookup_valid_i = 1'b0;
        bus.lookup_index_i = '0;
        bus.lookup_tag_i   = '0;
        bus.fill_valid_i   = 1'b0;
        bus.fill_index_i   = '0;
        bus.fill_way_i     = '0;
        bus.fill_tag_i     = '0;
        bus.flush_i        = 1'b0;

        // Reset values, then the post-reset walk.
        repeat (3) @(negedge clk_i);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        checkOutput("rst_resp_hit", 64'(bus.resp_hit_o), 64'd0);
        checkOutput("rst_resp_way", 64'(bus.resp_way_o), 64'd0);
        checkOutput("rst_resp_victim", 64'(bus.resp_victim_o), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy_o), 64'd1);
        checkOutput("rst_ready", 64'(bus.lookup_ready_o), 64'd0);
        rst_i = 1'b1;
        countBusy(-1, n, saw_ready);
        checkOutput("reset_walk_len", 64'(n), 64'd64);
        checkOutput("reset_walk_ready", 64'(saw_ready), 64'd0);

        doLookup(5, 52'h123, 1'b0);
        checkOutput("cold_valid", 64'(bus.resp_valid_o), 64'd1);
        checkOutput("cold_hit", 64'(bus.resp_hit_o), 64'd0);
        checkOutput("cold_victim", 64'(bus.resp_victim_o), 64'd0);

        // Fill all ways of set 5; pointer wraps back to 0 after way 3.
        for (int w = 0; w < 4; w++) doFill(5, w, 52'hA + 52'(w), 1'b0);
        doLookup(5, 52'hC, 1'b0);
        checkOutput("set5_hit_c", 64'(bus.resp_hit_o), 64'd1);
        checkOutput("set5_way_c", 64'(bus.resp_way_o), 64'd2);
        doLookup(5, 52'hE, 1'b0);
        checkOutput("set5_miss_hit", 64'(bus.resp_hit_o), 64'd0);
        checkOutput("set5_miss_victim", 64'(bus.resp_victim_o), 64'd0);

        // Lowest invalid way is preferred over the pointer.
        doFill(9, 1, 52'h91, 1'b0);
        doLookup(9, 52'h55, 1'b0);
        checkOutput("set9_victim_a", 64'(bus.resp_victim_o), 64'd0);
        doFill(9, 0, 52'h90, 1'b0);
        doLookup(9, 52'h55, 1'b0);
        checkOutput("set9_victim_b", 64'(bus.resp_victim_o), 64'd2);

        // Fill stalls a simultaneous lookup; the retried lookup sees the fill.
        applyStimulus(1'b1, 12, 52'h777, 1'b1, 12, 3, 52'h777, 1'b0);
        checkOutput("fill_stall_ready", 64'(last_ready), 64'd0);
        checkOutput("fill_stall_no_resp", 64'(bus.resp_valid_o), 64'd0);
        doLookup(12, 52'h777, 1'b0);
        checkOutput("after_fill_hit", 64'(bus.resp_hit_o), 64'd1);
        checkOutput("after_fill_way", 64'(bus.resp_way_o), 64'd3);

        // Lookup accepted in the flush cycle answers with pre-flush contents;
        // a second flush pulse mid-walk does not extend the walk.
        doLookup(5, 52'hB, 1'b1);
        checkOutput("flush_edge_valid", 64'(bus.resp_valid_o), 64'd1);
        checkOutput("flush_edge_hit", 64'(bus.resp_hit_o), 64'd1);
        checkOutput("flush_edge_way", 64'(bus.resp_way_o), 64'd1);
        countBusy(20, n, saw_ready);
        checkOutput("flush_walk_len", 64'(n), 64'd64);
        checkOutput("flush_walk_ready", 64'(saw_ready), 64'd0);
        doLookup(5, 52'hB, 1'b0);
        checkOutput("post_flush_hit5", 64'(bus.resp_hit_o), 64'd0);
        checkOutput("post_flush_victim5", 64'(bus.resp_victim_o), 64'd0);
        doLookup(9, 52'h91, 1'b0);
        checkOutput("post_flush_hit9", 64'(bus.resp_hit_o), 64'd0);
        checkOutput("post_flush_victim9", 64'(bus.resp_victim_o), 64'd0);
        doLookup(12, 52'h777, 1'b0);
        checkOutput("post_flush_hit12", 64'(bus.resp_hit_o), 64'd0);

        // Fill together with flush, then reset at walk cycle 30.
        doFill(20, 2, 52'h99, 1'b1);
        repeat (29) applyStimulus(1'b0, 0, '0, 1'b0, 0, 0, '0, 1'b0);
        checkOutput("pre_reset_busy", 64'(bus.busy_o), 64'd1);
        rst_i = 1'b0;
        #1;
        checkOutput("midrst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        checkOutput("midrst_busy", 64'(bus.busy_o), 64'd1);
        checkOutput("midrst_ready", 64'(bus.lookup_ready_o), 64'd0);
        checkOutput("midrst_victim", 64'(bus.resp_victim_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        countBusy(-1, n, saw_ready);
        checkOutput("midrst_walk_len", 64'(n), 64'd64);
        doLookup(20, 52'h99, 1'b0);
        checkOutput("fill_flush_hit", 64'(bus.resp_hit_o), 64'd0);
        checkOutput("fill_flush_victim", 64'(bus.resp_victim_o), 64'd0);

        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
